mod_148_timer_bank: RTL and testbench
=====================================

Name: mod_148_timer_bank

Overview:
- Synthesizable, multi-channel successor to the simulation-only Clause 148 timer wrappers.
- Provides NUM_TIMERS independent IEEE 802.3-style timers (start/stop, timer_done/timer_not_done) counted in bit times from a bit-time tick strobe.
- Each channel has a runtime-programmable duration, so one instance can serve plca_status_timer, beacon, burst and similar PLCA timers.
- Sits beside the PLCA control/status state machines, which drive the start/stop strobes and sample the done/not_done levels.

Parameters:
- NUM_TIMERS, 4, number of independent timer channels (>=1).
- CNT_W, 18, counter width in bit times; 18 covers 130090 + 10000 bit times.

Ports:
- clk  input  1  single block clock.
- reset  input  1  asynchronous, active-high reset.
- bit_tick  input  1  one-clk strobe per bit time, shared by all channels.
- start  input  NUM_TIMERS  per-channel one-clk start (or restart) strobe.
- stop  input  NUM_TIMERS  per-channel one-clk abort strobe.
- duration  input  NUM_TIMERS*CNT_W  per-channel duration in bit times; channel i uses bits [i*CNT_W +: CNT_W]; sampled only on start.
- timer_done  output  NUM_TIMERS  level; channel has expired.
- timer_not_done  output  NUM_TIMERS  level; channel is running.
- expired_pulse  output  NUM_TIMERS  one-clk pulse in the first cycle timer_done rises.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All state is registered on the rising edge of clk.
- Reset values: every channel IDLE, count=0, timer_done=0, timer_not_done=0, expired_pulse=0. Reset asserted mid-count aborts immediately with no pulse.
- Channel states and outputs:
  - IDLE: done=0, not_done=0.
  - RUNNING: done=0, not_done=1.
  - EXPIRED: done=1, not_done=0.
  - done and not_done are never both 1.
- Priority per channel each cycle: start > stop > bit_tick.
- start=1, any state:
  - If duration!=0: count<=duration, go to RUNNING. not_done rises the next cycle.
  - If duration==0: go directly to EXPIRED, asserting done and pulse the next cycle.
  - Restarting while RUNNING or EXPIRED reloads with no intervening done.
- stop=1 (without start), any state: go to IDLE. A simultaneous tick is ignored.
- RUNNING and bit_tick=1 (no start/stop): count<=count-1. If count==1, go to EXPIRED and set expired_pulse for exactly one cycle.
- bit_tick in the same cycle as start is ignored.
- Latency: start at cycle 0 with bit_tick held high gives ticks consumed at cycles 1..D and done visible from cycle D+1.
- Timing tolerance: a duration of D guarantees between D-1 and D bit times of elapsed real time, since start is asynchronous to the tick. Callers program the standard minimum+1.
- EXPIRED holds until start or stop; further ticks are ignored. The counter never wraps and never underflows below 0.
- duration changes while RUNNING have no effect.
- Channels are fully independent. Simultaneous events on different channels do not interact.

Decomposition:
- Shared package mod_148_timer_pkg:
  - Channel state typedef: IDLE/RUNNING/EXPIRED.
  - Bit-time duration constants: PLCA_STATUS_TIMER_MIN=130090, PLCA_STATUS_TIMER_TOL=10000, plus beacon/burst/to timer values used by the callers.
  - Default CNT_W.
- One sub-module, mod_148_timer_channel: a single counter plus state, generated NUM_TIMERS times by the bank.

Test Plan:
- Basic expiry:
  - Stimulus: reset, then ch0 duration=5, start pulse at cycle 0, bit_tick every cycle.
  - Required: not_done=1 for cycles 1..5; done=1 from cycle 6; expired_pulse only at cycle 6; other channels stay 0/0.
- Sparse ticks:
  - Stimulus: ch1 duration=130090, bit_tick every 10 clks.
  - Required: done rises exactly 1 clk after the 130090th tick; not_done drops in the same cycle.
- Restart and stop:
  - Stimulus: ch2 duration=10; start; after 4 ticks, start again; after 3 more ticks, stop.
  - Required: no done at any point; IDLE (0/0) the cycle after stop; a later tick has no effect.
- Simultaneous events:
  - Stimulus: start+stop+tick on ch3 in the same cycle with duration=3.
  - Required: RUNNING with count 3 (start wins). Then start with duration=0 → done=1 next cycle with a pulse and no not_done.
- Async reset mid-run:
  - Stimulus: all channels RUNNING; assert reset between clock edges.
  - Required: all outputs 0 immediately; no expired_pulse after release; the next start behaves as after power-up.

Source files
------------

// File: rtl/mod_148_timer_pkg.sv
// Shared definitions for the PLCA timer bank.
//   - timer_state_e : per-channel state (idle / running / expired)
//   - DEFAULT_CNT_W : default counter width in bit times
//   - PLCA timer durations in bit times, for the callers that program
//     the channels
package mod_148_timer_pkg;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_RUNNING = 2'd1,
    CH_EXPIRED = 2'd2
  } timer_state_e;

  // 18 bits hold the status timer minimum plus its tolerance (140090).
  localparam int DEFAULT_CNT_W = 18;

  localparam int PLCA_STATUS_TIMER_MIN    = 130090;
  localparam int PLCA_STATUS_TIMER_TOL    = 10000;
  localparam int PLCA_BEACON_TIMER        = 20;
  localparam int PLCA_BURST_TIMER_DEFAULT = 128;
  localparam int PLCA_TO_TIMER_DEFAULT    = 32;

endpackage

// File: rtl/mod_148_timer_channel.sv
// One timer channel: a down-counter in bit times plus a 3-state FSM.
// Ports:
//   clk, reset       - block clock, asynchronous active-high reset
//   bit_tick         - one-clk strobe per bit time
//   start            - load duration and run (duration 0 expires at once)
//   stop             - abort to idle
//   duration         - bit times, sampled only while start is high
//   timer_done       - level, channel has expired
//   timer_not_done   - level, channel is running
//   expired_pulse    - one clk in the first cycle timer_done is high
//   state            - current FSM state (debug)
// Per-cycle priority is start > stop > bit_tick. The strobes are plain
// one-cycle levels sampled on the rising edge of clk; there is no
// handshake back to the caller.
module mod_148_timer_channel
  import mod_148_timer_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_tick,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] duration,
  output logic             timer_done,
  output logic             timer_not_done,
  output logic             expired_pulse,
  output timer_state_e     state
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  timer_state_e     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pulse_q, pulse_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CH_IDLE;
      count_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (start) begin
      // A tick in the same cycle as start is deliberately dropped.
      if (duration == '0) begin
        state_d = CH_EXPIRED;
        count_d = '0;
      end else begin
        state_d = CH_RUNNING;
        count_d = duration;
      end
    end else if (stop) begin
      state_d = CH_IDLE;
      count_d = '0;
    end else if (bit_tick && (state_q == CH_RUNNING)) begin
      // RUNNING always holds count >= 1, so this never underflows.
      count_d = count_q - CNT_ONE;
      if (count_q == CNT_ONE) begin
        state_d = CH_EXPIRED;
      end
    end
    // Pulse only on a rising done; a zero-duration restart while already
    // expired keeps done high and does not pulse again.
    pulse_d = (state_d == CH_EXPIRED) && (state_q != CH_EXPIRED);
  end

  assign timer_done     = (state_q == CH_EXPIRED);
  assign timer_not_done = (state_q == CH_RUNNING);
  assign expired_pulse  = pulse_q;
  assign state          = state_q;

endmodule

// File: rtl/mod_148_timer_bank.sv
// Bank of NUM_TIMERS independent PLCA timers sharing one bit-time tick.
// Ports:
//   clk, reset      - block clock, asynchronous active-high reset
//   bit_tick        - one-clk strobe per bit time, shared by all channels
//   start, stop     - per-channel one-clk strobes (start wins over stop)
//   duration        - channel i uses bits [i*CNT_W +: CNT_W]
//   timer_done      - per-channel expired level
//   timer_not_done  - per-channel running level
//   expired_pulse   - per-channel one-clk pulse on expiry
//   state_dbg       - channel i state at bits [2*i +: 2] (debug)
module mod_148_timer_bank
  import mod_148_timer_pkg::*;
#(
  parameter int NUM_TIMERS = 4,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        bit_tick,
  input  logic [NUM_TIMERS-1:0]       start,
  input  logic [NUM_TIMERS-1:0]       stop,
  input  logic [NUM_TIMERS*CNT_W-1:0] duration,
  output logic [NUM_TIMERS-1:0]       timer_done,
  output logic [NUM_TIMERS-1:0]       timer_not_done,
  output logic [NUM_TIMERS-1:0]       expired_pulse,
  output logic [2*NUM_TIMERS-1:0]     state_dbg
);

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
    timer_state_e ch_state;

    mod_148_timer_channel #(
      .CNT_W(CNT_W)
    ) u_channel (
      .clk           (clk),
      .reset         (reset),
      .bit_tick      (bit_tick),
      .start         (start[i]),
      .stop          (stop[i]),
      .duration      (duration[i*CNT_W +: CNT_W]),
      .timer_done    (timer_done[i]),
      .timer_not_done(timer_not_done[i]),
      .expired_pulse (expired_pulse[i]),
      .state         (ch_state)
    );

    assign state_dbg[2*i +: 2] = ch_state;
  end

endmodule

// File: tb/tb_mod_148_timer_bank.sv
// Self-checking bench for mod_148_timer_bank: a per-channel behavioural
// model feeds an expected queue that is compared on every falling edge,
// plus directed scenarios with hand-computed literal expectations.
module tb_mod_148_timer_bank;
  import mod_148_timer_pkg::*;

  localparam int N  = 4;
  localparam int CW = 18;
  localparam int W  = 3 * N; // {pulse, not_done, done}

  logic            clk = 1'b0;
  logic            reset;
  logic            bit_tick;
  logic [N-1:0]    start;
  logic [N-1:0]    stop;
  logic [N*CW-1:0] duration;
  logic [N-1:0]    timer_done;
  logic [N-1:0]    timer_not_done;
  logic [N-1:0]    expired_pulse;
  logic [2*N-1:0]  state_dbg;

  mod_148_timer_bank #(.NUM_TIMERS(N), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .bit_tick      (bit_tick),
    .start         (start),
    .stop          (stop),
    .duration      (duration),
    .timer_done    (timer_done),
    .timer_not_done(timer_not_done),
    .expired_pulse (expired_pulse),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // mode: 0 idle, 1 running, 2 expired; rem = bit times still to elapse.
  int             m_mode [N];
  int             m_rem  [N];
  bit             m_pulse[N];
  logic [W-1:0]   exp_q[$];

  always @(posedge clk or posedge reset) begin
    logic [W-1:0] v;
    for (int c = 0; c < N; c++) begin
      if (reset) begin
        m_mode[c] = 0; m_rem[c] = 0; m_pulse[c] = 0;
      end else begin
        m_pulse[c] = 0;
        if (start[c]) begin
          int d;
          d = int'(duration[c*CW +: CW]);
          if (d == 0) begin
            if (m_mode[c] != 2) m_pulse[c] = 1;
            m_mode[c] = 2; m_rem[c] = 0;
          end else begin
            m_mode[c] = 1; m_rem[c] = d;
          end
        end else if (stop[c]) begin
          m_mode[c] = 0; m_rem[c] = 0;
        end else if (bit_tick && m_mode[c] == 1) begin
          m_rem[c] = m_rem[c] - 1;
          if (m_rem[c] == 0) begin
            m_mode[c] = 2; m_pulse[c] = 1;
          end
        end
      end
    end
    v = '0;
    for (int c = 0; c < N; c++) begin
      v[c]       = (m_mode[c] == 2);
      v[N + c]   = (m_mode[c] == 1);
      v[2*N + c] = m_pulse[c];
    end
    exp_q.push_back(v);
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q[$];
      exp_q.delete();
      for (int c = 0; c < N; c++) begin
        check($sformatf("sb ch%0d done", c), 32'(timer_done[c]), 32'(e[c]));
        check($sformatf("sb ch%0d not_done", c), 32'(timer_not_done[c]), 32'(e[N + c]));
        check($sformatf("sb ch%0d pulse", c), 32'(expired_pulse[c]), 32'(e[2*N + c]));
      end
      check("sb exclusive", 32'(timer_done & timer_not_done), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dur(input int c, input int d);
    duration[c*CW +: CW] = CW'(d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    bit_tick = 1'b0;
    start    = '0;
    stop     = '0;
    duration = '0;
    repeat (3) step();
    check("reset done", 32'(timer_done), 32'd0);
    check("reset not_done", 32'(timer_not_done), 32'd0);
    check("reset pulse", 32'(expired_pulse), 32'd0);
    reset = 1'b0;
    step();

    // Basic expiry: ch0, duration 5, tick every cycle.
    set_dur(0, 5);
    start[0] = 1'b1;
    bit_tick = 1'b1;
    step();
    start[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("basic c%0d not_done", k), 32'(timer_not_done[0]), 32'd1);
      check($sformatf("basic c%0d done", k), 32'(timer_done[0]), 32'd0);
      check($sformatf("basic c%0d pulse", k), 32'(expired_pulse[0]), 32'd0);
      step();
    end
    check("basic c6 done", 32'(timer_done[0]), 32'd1);
    check("basic c6 not_done", 32'(timer_not_done[0]), 32'd0);
    check("basic c6 pulse", 32'(expired_pulse[0]), 32'd1);
    check("basic others", 32'({timer_done[3:1], timer_not_done[3:1]}), 32'd0);
    step();
    check("basic c7 pulse", 32'(expired_pulse[0]), 32'd0);
    check("basic c7 done held", 32'(timer_done[0]), 32'd1);
    bit_tick = 1'b0;
    stop[0] = 1'b1;
    step();
    stop[0] = 1'b0;
    check("basic stop idle", 32'({timer_done[0], timer_not_done[0]}), 32'd0);

    // Sparse ticks: ch1, duration 20, one tick every 10 clks.
    set_dur(1, 20);
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      repeat (9) step();
      bit_tick = 1'b1;
      if (t == 20) check("sparse last tick not_done", 32'(timer_not_done[1]), 32'd1);
      step();
      bit_tick = 1'b0;
    end
    check("sparse done", 32'(timer_done[1]), 32'd1);
    check("sparse not_done dropped", 32'(timer_not_done[1]), 32'd0);
    check("sparse pulse", 32'(expired_pulse[1]), 32'd1);

    // Full status-timer duration on ch1: stays running after many ticks.
    set_dur(1, PLCA_STATUS_TIMER_MIN);
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    check("long restart no done", 32'(timer_done[1]), 32'd0);
    bit_tick = 1'b1;
    repeat (3000) step();
    bit_tick = 1'b0;
    check("long still running", 32'(timer_not_done[1]), 32'd1);
    stop[1] = 1'b1;
    step();
    stop[1] = 1'b0;

    // Restart and stop: ch2, duration 10.
    set_dur(2, 10);
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    bit_tick = 1'b1;
    repeat (4) step();
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    repeat (3) step();
    check("restart running", 32'(timer_not_done[2]), 32'd1);
    stop[2] = 1'b1;
    step();
    stop[2] = 1'b0;
    check("restart stop idle", 32'({timer_done[2], timer_not_done[2]}), 32'd0);
    step();
    check("restart tick after stop", 32'({timer_done[2], timer_not_done[2]}), 32'd0);
    bit_tick = 1'b0;

    // Simultaneous start+stop+tick on ch3: start wins, count 3.
    set_dur(3, 3);
    start[3] = 1'b1;
    stop[3]  = 1'b1;
    bit_tick = 1'b1;
    step();
    start[3] = 1'b0;
    stop[3]  = 1'b0;
    check("simul c1 running", 32'(timer_not_done[3]), 32'd1);
    step();
    check("simul c2 running", 32'(timer_not_done[3]), 32'd1);
    step();
    check("simul c3 running", 32'(timer_not_done[3]), 32'd1);
    step();
    check("simul c4 done", 32'(timer_done[3]), 32'd1);
    check("simul c4 pulse", 32'(expired_pulse[3]), 32'd1);
    bit_tick = 1'b0;
    stop[3] = 1'b1;
    step();
    stop[3] = 1'b0;
    set_dur(3, 0);
    start[3] = 1'b1;
    step();
    start[3] = 1'b0;
    check("zero dur done", 32'(timer_done[3]), 32'd1);
    check("zero dur pulse", 32'(expired_pulse[3]), 32'd1);
    check("zero dur not_done", 32'(timer_not_done[3]), 32'd0);
    step();
    check("zero dur pulse gone", 32'(expired_pulse[3]), 32'd0);

    // Asynchronous reset mid-run.
    for (int c = 0; c < N; c++) set_dur(c, 50);
    start    = '1;
    bit_tick = 1'b1;
    step();
    start = '0;
    repeat (5) step();
    check("pre-reset all running", 32'(timer_not_done), 32'hF);
    #2;
    reset = 1'b1;
    #1;
    check("async reset done", 32'(timer_done), 32'd0);
    check("async reset not_done", 32'(timer_not_done), 32'd0);
    check("async reset pulse", 32'(expired_pulse), 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 60; k++) begin
      check("post-reset no activity", 32'({expired_pulse, timer_done, timer_not_done}), 32'd0);
      step();
    end
    set_dur(0, 2);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    check("post-reset c1 running", 32'(timer_not_done[0]), 32'd1);
    step();
    check("post-reset c2 running", 32'(timer_not_done[0]), 32'd1);
    step();
    check("post-reset c3 done", 32'(timer_done[0]), 32'd1);
    check("post-reset c3 pulse", 32'(expired_pulse[0]), 32'd1);
    bit_tick = 1'b0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
